// File: rtl/log2_stage_arbiter.sv
// -----------------------------------------------------------------------------
// log2_stage_arbiter
//
// Shares one stage1_log2_approx instance among N_REQ requesters (softmax tree
// nodes). Requests are granted round-robin and the winner's operands are
// registered onto the stage inputs. The stage runs in lockstep with i_en, so a
// tag delay line that advances on the same enable carries each requester ID
// alongside its data. When the data leaves the stage, the result and the
// bypassed operands go back to the issuing requester. If the stage's o_valid
// ever disagrees with the tag line, a sticky error is raised and no response
// is emitted for that cycle.
//
// Ports
//   i_clk, i_rst_n     clock (rising edge), asynchronous active-low reset
//   i_en               global enable; 0 freezes the arbiter and the stage
//   i_req_valid        per-requester request valid
//   i_req_in0/in1      packed operands, requester k at [k*DW +: DW]
//   o_req_ready        one-hot grant (accept = valid & ready)
//   o_stg_en           stage enable (= i_en)
//   o_stg_valid        stage i_valid
//   o_stg_in0/in1      stage operands
//   i_stg_valid        stage o_valid
//   i_stg_log2         stage log2(in0)
//   i_stg_in0/in1_byp  stage bypassed operands
//   o_rsp_valid        response valid (one enabled-cycle pulse)
//   o_rsp_id           requester ID of the response
//   o_rsp_log2         log2(in0), Q6.10
//   o_rsp_in0/in1      bypassed operands
//   o_busy             a request is issued but not yet responded
//   o_err              sticky tag/stage valid mismatch
// -----------------------------------------------------------------------------
module log2_stage_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DW      = 16,
  parameter int STG_LAT = 1,
  parameter int IDW     = $clog2(N_REQ)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic [N_REQ-1:0]      i_req_valid,
  input  logic [N_REQ*DW-1:0]   i_req_in0,
  input  logic [N_REQ*DW-1:0]   i_req_in1,
  output logic [N_REQ-1:0]      o_req_ready,
  output logic                  o_stg_en,
  output logic                  o_stg_valid,
  output logic [DW-1:0]         o_stg_in0,
  output logic [DW-1:0]         o_stg_in1,
  input  logic                  i_stg_valid,
  input  logic [DW-1:0]         i_stg_log2,
  input  logic [DW-1:0]         i_stg_in0_byp,
  input  logic [DW-1:0]         i_stg_in1_byp,
  output logic                  o_rsp_valid,
  output logic [IDW-1:0]        o_rsp_id,
  output logic [DW-1:0]         o_rsp_log2,
  output logic [DW-1:0]         o_rsp_in0,
  output logic [DW-1:0]         o_rsp_in1,
  output logic                  o_busy,
  output logic                  o_err
);

  // One tag per slot: the stage register that holds o_stg_valid counts as
  // slot 0, followed by STG_LAT slots matching the stage's own pipeline.
  localparam int TAG_N = STG_LAT + 1;

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
  } tag_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [IDW-1:0] rr_ptr_q,    rr_ptr_d;
  logic           stg_valid_q, stg_valid_d;
  logic [DW-1:0]  stg_in0_q,   stg_in0_d;
  logic [DW-1:0]  stg_in1_q,   stg_in1_d;
  tag_t           tag_q [TAG_N];
  tag_t           tag_d [TAG_N];
  logic           rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q,    rsp_id_d;
  logic [DW-1:0]  rsp_log2_q,  rsp_log2_d;
  logic [DW-1:0]  rsp_in0_q,   rsp_in0_d;
  logic [DW-1:0]  rsp_in1_q,   rsp_in1_d;
  logic           err_q,       err_d;

  // ---------------------------------------------------------------------------
  // Round-robin arbiter: first valid requester at or after rr_ptr, wrapping.
  // ---------------------------------------------------------------------------
  logic [N_REQ-1:0] gnt;
  logic [IDW-1:0]   win_id;
  logic             accept;
  logic [DW-1:0]    win_in0;
  logic [DW-1:0]    win_in1;

  always_comb begin : arbiter
    logic [IDW-1:0] idx;
    // NOTE: every signal written here gets a default before any branch;
    // a path that leaves one unassigned would infer a latch.
    gnt    = '0;
    win_id = '0;
    accept = 1'b0;
    idx    = '0;
    if (i_en) begin
      for (int i = 0; i < N_REQ; i++) begin
        idx = IDW'((int'(rr_ptr_q) + i) % N_REQ);
        if (!accept && i_req_valid[idx]) begin
          accept      = 1'b1;
          gnt[idx]    = 1'b1;
          win_id      = idx;
        end
      end
    end
  end

  assign win_in0 = i_req_in0[int'(win_id)*DW +: DW];
  assign win_in1 = i_req_in1[int'(win_id)*DW +: DW];

  // ---------------------------------------------------------------------------
  // Next-state logic. With i_en low every register keeps its value, which
  // also stretches a pending response pulse until the pipeline moves again.
  // ---------------------------------------------------------------------------
  always_comb begin : next_state
    rr_ptr_d    = rr_ptr_q;
    stg_valid_d = stg_valid_q;
    stg_in0_d   = stg_in0_q;
    stg_in1_d   = stg_in1_q;
    tag_d       = tag_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_log2_d  = rsp_log2_q;
    rsp_in0_d   = rsp_in0_q;
    rsp_in1_d   = rsp_in1_q;
    err_d       = err_q;

    if (i_en) begin
      // Issue side.
      stg_valid_d = accept;
      if (accept) begin
        rr_ptr_d  = (win_id == IDW'(N_REQ - 1)) ? '0 : win_id + 1'b1;
        stg_in0_d = win_in0;
        stg_in1_d = win_in1;
      end

      // Tag line moves in lockstep with the stage.
      tag_d[0].vld = accept;
      tag_d[0].id  = win_id;
      for (int s = 1; s < TAG_N; s++) begin
        tag_d[s] = tag_q[s-1];
      end

      // Response side: the tail tag lines up with the stage output.
      rsp_id_d   = tag_q[TAG_N-1].id;
      rsp_log2_d = i_stg_log2;
      rsp_in0_d  = i_stg_in0_byp;
      rsp_in1_d  = i_stg_in1_byp;
      if (i_stg_valid != tag_q[TAG_N-1].vld) begin
        err_d       = 1'b1;
        rsp_valid_d = 1'b0;
      end else begin
        rsp_valid_d = i_stg_valid;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so that
  // every flop samples the values from before the clock edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_ptr_q    <= '0;
      stg_valid_q <= 1'b0;
      stg_in0_q   <= '0;
      stg_in1_q   <= '0;
      // NOTE: the tag line is reset slot by slot (it is small); in-flight
      // tags must vanish on reset or they would produce stale responses.
      for (int s = 0; s < TAG_N; s++) begin
        tag_q[s] <= '0;
      end
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_log2_q  <= '0;
      rsp_in0_q   <= '0;
      rsp_in1_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      stg_valid_q <= stg_valid_d;
      stg_in0_q   <= stg_in0_d;
      stg_in1_q   <= stg_in1_d;
      tag_q       <= tag_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_log2_q  <= rsp_log2_d;
      rsp_in0_q   <= rsp_in0_d;
      rsp_in1_q   <= rsp_in1_d;
      err_q       <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  logic busy;

  always_comb begin : busy_or
    busy = stg_valid_q;
    for (int s = 0; s < TAG_N; s++) begin
      busy = busy | tag_q[s].vld;
    end
  end

  assign o_req_ready = gnt;
  assign o_stg_en    = i_en;
  assign o_stg_valid = stg_valid_q;
  assign o_stg_in0   = stg_in0_q;
  assign o_stg_in1   = stg_in1_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_id    = rsp_id_q;
  assign o_rsp_log2  = rsp_log2_q;
  assign o_rsp_in0   = rsp_in0_q;
  assign o_rsp_in1   = rsp_in1_q;
  assign o_busy      = busy;
  assign o_err       = err_q;

endmodule

// File: tb/tb_log2_stage_arbiter.sv
// -----------------------------------------------------------------------------
// tb_log2_stage_arbiter
//
// Drives log2_stage_arbiter together with a behavioural stand-in for the
// shared log2 stage. The reference keeps a round-robin pointer as a plain
// integer, a queue of accepted requests with the enabled-edge count at which
// each response is due, and computes log2 with a Mitchell approximation.
// -----------------------------------------------------------------------------
module tb_log2_stage_arbiter;

  localparam int N_REQ   = 4;
  localparam int DW      = 16;
  localparam int STG_LAT = 1;
  localparam int IDW     = 2;

  logic                i_clk;
  logic                i_rst_n;
  logic                i_en;
  logic [N_REQ-1:0]    i_req_valid;
  logic [N_REQ*DW-1:0] i_req_in0;
  logic [N_REQ*DW-1:0] i_req_in1;
  logic [N_REQ-1:0]    o_req_ready;
  logic                o_stg_en;
  logic                o_stg_valid;
  logic [DW-1:0]       o_stg_in0;
  logic [DW-1:0]       o_stg_in1;
  logic                i_stg_valid;
  logic [DW-1:0]       i_stg_log2;
  logic [DW-1:0]       i_stg_in0_byp;
  logic [DW-1:0]       i_stg_in1_byp;
  logic                o_rsp_valid;
  logic [IDW-1:0]      o_rsp_id;
  logic [DW-1:0]       o_rsp_log2;
  logic [DW-1:0]       o_rsp_in0;
  logic [DW-1:0]       o_rsp_in1;
  logic                o_busy;
  logic                o_err;

  log2_stage_arbiter #(
    .N_REQ(N_REQ), .DW(DW), .STG_LAT(STG_LAT), .IDW(IDW)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en),
    .i_req_valid(i_req_valid), .i_req_in0(i_req_in0), .i_req_in1(i_req_in1),
    .o_req_ready(o_req_ready),
    .o_stg_en(o_stg_en), .o_stg_valid(o_stg_valid),
    .o_stg_in0(o_stg_in0), .o_stg_in1(o_stg_in1),
    .i_stg_valid(i_stg_valid), .i_stg_log2(i_stg_log2),
    .i_stg_in0_byp(i_stg_in0_byp), .i_stg_in1_byp(i_stg_in1_byp),
    .o_rsp_valid(o_rsp_valid), .o_rsp_id(o_rsp_id), .o_rsp_log2(o_rsp_log2),
    .o_rsp_in0(o_rsp_in0), .o_rsp_in1(o_rsp_in1),
    .o_busy(o_busy), .o_err(o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Mitchell log2 of a positive Q6.10 value: msb position gives the integer
  // part, the bits below the msb give the fraction. Non-positive -> 0.
  function automatic logic [DW-1:0] ref_log2(input logic [DW-1:0] x);
    int          p;
    logic [31:0] m;
    if ($signed(x) <= 0) return '0;
    p = 0;
    for (int b = 0; b < DW; b++) if (x[b]) p = b;
    m = ({16'h0, x} << (15 - p)) & 32'h0000_7FFF;
    return DW'(((p - 10) * 1024) + int'(m >> 5));
  endfunction

  // ---------------------------------------------------------------------------
  // Stand-in for the shared stage: STG_LAT enabled cycles, frozen by o_stg_en.
  // ---------------------------------------------------------------------------
  logic          sv_pipe [STG_LAT];
  logic [DW-1:0] sl_pipe [STG_LAT];
  logic [DW-1:0] s0_pipe [STG_LAT];
  logic [DW-1:0] s1_pipe [STG_LAT];
  logic          stg_inj;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < STG_LAT; s++) begin
        sv_pipe[s] <= 1'b0;
        sl_pipe[s] <= '0;
        s0_pipe[s] <= '0;
        s1_pipe[s] <= '0;
      end
    end else if (o_stg_en) begin
      sv_pipe[0] <= o_stg_valid;
      sl_pipe[0] <= ref_log2(o_stg_in0);
      s0_pipe[0] <= o_stg_in0;
      s1_pipe[0] <= o_stg_in1;
      for (int s = 1; s < STG_LAT; s++) begin
        sv_pipe[s] <= sv_pipe[s-1];
        sl_pipe[s] <= sl_pipe[s-1];
        s0_pipe[s] <= s0_pipe[s-1];
        s1_pipe[s] <= s1_pipe[s-1];
      end
    end
  end

  assign i_stg_valid   = sv_pipe[STG_LAT-1] | stg_inj;
  assign i_stg_log2    = sl_pipe[STG_LAT-1];
  assign i_stg_in0_byp = s0_pipe[STG_LAT-1];
  assign i_stg_in1_byp = s1_pipe[STG_LAT-1];

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  typedef struct {
    int            id;
    logic [DW-1:0] in0;
    logic [DW-1:0] in1;
    int            due;
  } item_t;

  item_t         sb[$];
  bit            pend [N_REQ];
  logic [DW-1:0] rq0  [N_REQ];
  logic [DW-1:0] rq1  [N_REQ];
  int            rr_m;
  int            en_edges;
  bit            exp_stg_v;
  logic [DW-1:0] exp_stg0, exp_stg1;
  bit            exp_rv;
  item_t         exp_rsp;
  bit            exp_err;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_req(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b);
    pend[k] = 1'b1;
    rq0[k]  = a;
    rq1[k]  = b;
  endtask

  // One clock cycle: drive at the start, predict the grant, clock, then
  // check everything the DUT registered on that edge.
  task automatic step(input bit en, input bit inj);
    logic [N_REQ-1:0] eg;
    int               w;
    int               k;
    i_en    = en;
    stg_inj = inj;
    for (int r = 0; r < N_REQ; r++) begin
      i_req_valid[r]          = pend[r];
      i_req_in0[r*DW +: DW]   = rq0[r];
      i_req_in1[r*DW +: DW]   = rq1[r];
    end
    #1;
    eg = '0;
    w  = -1;
    if (en) begin
      for (int i = 0; i < N_REQ; i++) begin
        k = (rr_m + i) % N_REQ;
        if (w < 0 && pend[k]) w = k;
      end
    end
    if (w >= 0) eg[w] = 1'b1;
    check("grant", 32'(o_req_ready), 32'(eg));
    if (en) begin
      exp_stg_v = (w >= 0);
      if (w >= 0) begin
        exp_stg0 = rq0[w];
        exp_stg1 = rq1[w];
        sb.push_back('{id: w, in0: rq0[w], in1: rq1[w], due: en_edges + STG_LAT + 2});
        rr_m    = (w + 1) % N_REQ;
        pend[w] = 1'b0;
      end
      if (inj) exp_err = 1'b1;
    end
    @(posedge i_clk);
    @(negedge i_clk);
    if (en) begin
      en_edges++;
      exp_rv = 1'b0;
      if (sb.size() > 0 && sb[0].due == en_edges) begin
        exp_rv  = 1'b1;
        exp_rsp = sb.pop_front();
      end
    end
    check("rsp_valid", 32'(o_rsp_valid), 32'(exp_rv));
    if (exp_rv) begin
      check("rsp_id",   32'(o_rsp_id),   32'(exp_rsp.id));
      check("rsp_log2", 32'(o_rsp_log2), 32'(ref_log2(exp_rsp.in0)));
      check("rsp_in0",  32'(o_rsp_in0),  32'(exp_rsp.in0));
      check("rsp_in1",  32'(o_rsp_in1),  32'(exp_rsp.in1));
    end
    check("stg_valid", 32'(o_stg_valid), 32'(exp_stg_v));
    if (exp_stg_v) begin
      check("stg_in0", 32'(o_stg_in0), 32'(exp_stg0));
      check("stg_in1", 32'(o_stg_in1), 32'(exp_stg1));
    end
    check("busy", 32'(o_busy), 32'(sb.size() > 0));
    check("err",  32'(o_err),  32'(exp_err));
  endtask

  task automatic drain();
    repeat (STG_LAT + 4) step(1'b1, 1'b0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear at once.
  task automatic do_reset();
    #2;
    i_rst_n = 1'b0;
    for (int r = 0; r < N_REQ; r++) pend[r] = 1'b0;
    sb.delete();
    rr_m      = 0;
    exp_stg_v = 1'b0;
    exp_rv    = 1'b0;
    exp_err   = 1'b0;
    stg_inj   = 1'b0;
    #1;
    check("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("rst_rsp_id",    32'(o_rsp_id),    32'd0);
    check("rst_rsp_log2",  32'(o_rsp_log2),  32'd0);
    check("rst_stg_valid", 32'(o_stg_valid), 32'd0);
    check("rst_busy",      32'(o_busy),      32'd0);
    check("rst_err",       32'(o_err),       32'd0);
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  initial begin
    i_rst_n     = 1'b0;
    i_en        = 1'b0;
    i_req_valid = '0;
    i_req_in0   = '0;
    i_req_in1   = '0;
    stg_inj     = 1'b0;
    rr_m        = 0;
    en_edges    = 0;
    exp_stg_v   = 1'b0;
    exp_stg0    = '0;
    exp_stg1    = '0;
    exp_rv      = 1'b0;
    exp_rsp     = '{id: 0, in0: '0, in1: '0, due: 0};
    exp_err     = 1'b0;
    for (int r = 0; r < N_REQ; r++) begin
      pend[r] = 1'b0;
      rq0[r]  = '0;
      rq1[r]  = '0;
    end

    // Power-on reset state.
    #3;
    check("por_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("por_busy",      32'(o_busy),      32'd0);
    check("por_err",       32'(o_err),       32'd0);
    check("por_ready",     32'(o_req_ready), 32'd0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Single request from requester 2: log2(1.0) = 0.
    set_req(2, 16'h0400, 16'h0040);
    step(1'b1, 1'b0);
    drain();

    // All four valid and refilled every cycle from rr_ptr = 0.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      for (int r = 0; r < N_REQ; r++)
        if (!pend[r]) set_req(r, 16'h0800, DW'($urandom_range(0, 16'hFFFF)));
      step(1'b1, 1'b0);
    end
    drain();

    // Wrap: requester 3 alone, then 0 and 3 together.
    do_reset();
    set_req(3, 16'h1000, 16'h0003);
    step(1'b1, 1'b0);
    set_req(0, 16'h0200, 16'h0000);
    set_req(3, 16'h0C00, 16'h0033);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    drain();

    // Three-cycle stall in the middle of a saturated stream.
    for (int c = 0; c < 10; c++) begin
      for (int r = 0; r < N_REQ; r++)
        if (!pend[r]) set_req(r, DW'($urandom_range(1, 16'h7FFF)), DW'($urandom_range(0, 16'hFFFF)));
      step(!(c >= 4 && c < 7), 1'b0);
    end
    drain();

    // Stage valid with an empty tag line: sticky error, no response.
    step(1'b1, 1'b1);
    repeat (3) step(1'b1, 1'b0);
    set_req(1, 16'h0400, 16'h0001);
    drain();

    // Reset with several requests in flight: nothing stale afterwards.
    do_reset();
    set_req(0, 16'h0500, 16'h0010);
    set_req(1, 16'h0600, 16'h0020);
    set_req(2, 16'h0700, 16'h0030);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    do_reset();
    drain();

    // Randomised traffic with occasional stalls.
    for (int c = 0; c < 400; c++) begin
      for (int r = 0; r < N_REQ; r++)
        if (!pend[r] && $urandom_range(0, 1) == 1)
          set_req(r, DW'($urandom_range(1, 16'h7FFF)), DW'($urandom_range(0, 16'hFFFF)));
      step($urandom_range(0, 9) != 0, 1'b0);
    end
    for (int r = 0; r < N_REQ; r++) pend[r] = 1'b0;
    drain();
    check("drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
